// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and flag type for the multi-cycle ALU.
// ALU_MUL_EN selects whether opcode E is a multiply or an alias of PASS.
package alu_pkg;

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpAdc  = 4'h1;
  localparam logic [3:0] OpSub  = 4'h2;
  localparam logic [3:0] OpSbc  = 4'h3;
  localparam logic [3:0] OpAnd  = 4'h4;
  localparam logic [3:0] OpOr   = 4'h5;
  localparam logic [3:0] OpXor  = 4'h6;
  localparam logic [3:0] OpNot  = 4'h7;
  localparam logic [3:0] OpInc  = 4'h8;
  localparam logic [3:0] OpDec  = 4'h9;
  localparam logic [3:0] OpShl  = 4'hA;
  localparam logic [3:0] OpShr  = 4'hB;
  localparam logic [3:0] OpRol  = 4'hC;
  localparam logic [3:0] OpRor  = 4'hD;
  localparam logic [3:0] OpMul  = 4'hE;
  localparam logic [3:0] OpPass = 4'hF;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  // PASS (and opcode E when no multiplier is built) leaves the CCR untouched.
  function automatic logic is_flag_op(input logic [3:0] op);
`ifdef ALU_MUL_EN
    return op != OpPass;
`else
    return (op != OpPass) && (op != OpMul);
`endif
  endfunction

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op >= OpShl) && (op <= OpRor);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational Z/N/C/V derivation from opcode, operand signs, raw carry and final result.
// Multiply-specific N/C rules exist only when ALU_MUL_EN is defined.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [3:0]       op_i,
  input  logic             a_msb_i,
  input  logic             b_msb_i,
  input  logic [WIDTH-1:0] res_i,
  input  logic [WIDTH-1:0] res_hi_i,
  input  logic             carry_i,
  output flags_t           flags_o
);

  logic r_msb;
  assign r_msb = res_i[WIDTH-1];

  always_comb begin
    flags_o   = '0;
    // result_hi is zero for every non-multiply op, so this covers both cases.
    flags_o.z = ({res_hi_i, res_i} == '0);
    flags_o.n = r_msb;
    case (op_i)
      OpAdd, OpAdc: begin
        flags_o.c = carry_i;
        flags_o.v = (a_msb_i == b_msb_i) && (r_msb != a_msb_i);
      end
      OpSub, OpSbc: begin
        flags_o.c = carry_i;
        flags_o.v = (a_msb_i != b_msb_i) && (r_msb != a_msb_i);
      end
      OpInc: begin
        flags_o.c = carry_i;
        flags_o.v = ~a_msb_i & r_msb;
      end
      OpDec: begin
        flags_o.c = carry_i;
        flags_o.v = a_msb_i & ~r_msb;
      end
      OpShl, OpShr, OpRol, OpRor: flags_o.c = carry_i;
`ifdef ALU_MUL_EN
      OpMul: begin
        flags_o.n = res_hi_i[WIDTH-1];
        flags_o.c = (res_hi_i != '0);
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU feeding the CCR: one-cycle arith/logic, bit-serial shifts and
// shift-and-add multiply. Define ALU_MUL_EN to build the multiplier (opcode E).
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             flag_en
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH:0] SumOne = {{WIDTH{1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             wc_q, wc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  flags_t           flags_q, flags_d;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]   msum;
`endif

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic [WIDTH-1:0] it_acc, it_hi;
  logic             it_c;
  logic             is_exec, iter_start;
  logic [3:0]       fg_op;
  logic             fg_a_msb;
  logic [WIDTH-1:0] fg_res, fg_hi;
  logic             fg_c;
  flags_t           fg_flags;

  assign shamt   = b[SHW-1:0];
  assign is_exec = (state_q == StExec);

`ifdef ALU_MUL_EN
  assign iter_start = (is_shift_op(op) && (shamt != '0)) || (op == OpMul);
`else
  assign iter_start = is_shift_op(op) && (shamt != '0);
`endif

  // Single-cycle datapath; shifts by zero and PASS fall through as result = a.
  always_comb begin
    sum      = '0;
    sc_res   = a;
    sc_carry = 1'b0;
    case (op)
      OpAdd: sum = {1'b0, a} + {1'b0, b};
      OpAdc: sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      OpSub: sum = {1'b0, a} - {1'b0, b};
      OpSbc: sum = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
      OpInc: sum = {1'b0, a} + SumOne;
      OpDec: sum = {1'b0, a} - SumOne;
      OpAnd: sc_res = a & b;
      OpOr:  sc_res = a | b;
      OpXor: sc_res = a ^ b;
      OpNot: sc_res = ~a;
      default: ;
    endcase
    if ((op <= OpSbc) || (op == OpInc) || (op == OpDec)) begin
      sc_res   = sum[WIDTH-1:0];
      sc_carry = sum[WIDTH];
    end
  end

  // One shift step or one multiply step per EXEC cycle.
  always_comb begin
    it_acc = acc_q;
    it_hi  = hi_q;
    it_c   = wc_q;
`ifdef ALU_MUL_EN
    msum   = '0;
`endif
    case (op_q)
      OpShl: begin
        it_c   = acc_q[WIDTH-1];
        it_acc = {acc_q[WIDTH-2:0], 1'b0};
      end
      OpShr: begin
        it_c   = acc_q[0];
        it_acc = {1'b0, acc_q[WIDTH-1:1]};
      end
      OpRol: begin
        it_c   = acc_q[WIDTH-1];
        it_acc = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
      end
      OpRor: begin
        it_c   = acc_q[0];
        it_acc = {acc_q[0], acc_q[WIDTH-1:1]};
      end
`ifdef ALU_MUL_EN
      OpMul: begin
        msum   = {1'b0, hi_q} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        it_hi  = msum[WIDTH:1];
        it_acc = {msum[0], acc_q[WIDTH-1:1]};
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    fg_op    = is_exec ? op_q : op;
    fg_a_msb = is_exec ? acc_q[WIDTH-1] : a[WIDTH-1];
    fg_res   = is_exec ? it_acc : sc_res;
    fg_hi    = is_exec ? it_hi : '0;
    fg_c     = is_exec ? it_c : sc_carry;
  end

  alu_flag_gen #(
    .WIDTH(WIDTH)
  ) u_flag_gen (
    .op_i    (fg_op),
    .a_msb_i (fg_a_msb),
    .b_msb_i (b[WIDTH-1]),
    .res_i   (fg_res),
    .res_hi_i(fg_hi),
    .carry_i (fg_c),
    .flags_o (fg_flags)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    wc_d     = wc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    flags_d  = flags_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          op_d = op;
          if (iter_start) begin
            acc_d   = a;
            hi_d    = '0;
            wc_d    = 1'b0;
            cnt_d   = is_shift_op(op) ? CW'(shamt) : CW'(WIDTH);
`ifdef ALU_MUL_EN
            mcand_d = b;
`endif
            state_d = StExec;
          end else begin
            res_d    = sc_res;
            res_hi_d = '0;
            flags_d  = fg_flags;
            state_d  = StDone;
          end
        end
      end
      StExec: begin
        acc_d = it_acc;
        hi_d  = it_hi;
        wc_d  = it_c;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d    = it_acc;
          res_hi_d = it_hi;
          flags_d  = fg_flags;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      wc_q     <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      wc_q     <= wc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
`endif
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign flag_en   = done && is_flag_op(op_q);
  assign result    = res_q;
  assign result_hi = res_hi_q;
  assign Z         = flags_q.z;
  assign N         = flags_q.n;
  assign C         = flags_q.c;
  assign V         = flags_q.v;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc (WIDTH=8); multiply vectors only under ALU_MUL_EN.
module tb_alu_mc;

  logic       clk = 1'b0;
  logic       rst, start, cin;
  logic [3:0] op;
  logic [7:0] a, b;
  logic       busy, done, Z, N, C, V, flag_en;
  logic [7:0] result, result_hi;

  int checks   = 0;
  int failures = 0;

  alu_mc #(
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .result_hi(result_hi),
    .Z        (Z),
    .N        (N),
    .C        (C),
    .V        (V),
    .flag_en  (flag_en)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and wait (bounded) for done; lat=1 means done in the cycle after start.
  task automatic run_op(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, output int lat);
    @(negedge clk);
    op = o; a = av; b = bv; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [3:0] o, input logic [7:0] av,
                       input logic [7:0] bv, input logic ci, input int exp_lat,
                       input logic [7:0] er, input logic [7:0] eh, input logic [3:0] ef,
                       input logic efen);
    int lat;
    run_op(o, av, bv, ci, lat);
    check_val({tag, "/latency"}, lat, exp_lat);
    check_val({tag, "/busy"}, busy, 1'b1);
    check_val({tag, "/result"}, result, er);
    check_val({tag, "/result_hi"}, result_hi, eh);
    check_val({tag, "/ZNCV"}, {Z, N, C, V}, ef);
    check_val({tag, "/flag_en"}, flag_en, efen);
    @(negedge clk);
    check_val({tag, "/done_pulse"}, {done, busy}, 2'b00);
    check_val({tag, "/hold"}, {result, Z, N, C, V}, {er, ef});
  endtask

  initial begin
    int dones;
    int first;
    rst = 1'b1; start = 1'b0; op = 4'h0; a = 8'h00; b = 8'h00; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("reset/outputs", {busy, done, flag_en, result, result_hi, Z, N, C, V}, 23'd0);

    //       tag      op    a      b      cin lat res    hi     ZNCV     fen
    do_op("add_ovf",  4'h0, 8'h7F, 8'h01, 0,  1,  8'h80, 8'h00, 4'b0101, 1);
    do_op("sub_brw",  4'h2, 8'h10, 8'h20, 0,  1,  8'hF0, 8'h00, 4'b0110, 1);
    do_op("sbc_cin",  4'h3, 8'h00, 8'h00, 1,  1,  8'hFF, 8'h00, 4'b0110, 1);
    do_op("adc_wrap", 4'h1, 8'hFF, 8'h00, 1,  1,  8'h00, 8'h00, 4'b1010, 1);
    do_op("inc_wrap", 4'h8, 8'hFF, 8'h00, 0,  1,  8'h00, 8'h00, 4'b1010, 1);
    do_op("inc_ovf",  4'h8, 8'h7F, 8'h00, 0,  1,  8'h80, 8'h00, 4'b0101, 1);
    do_op("dec_wrap", 4'h9, 8'h00, 8'h00, 0,  1,  8'hFF, 8'h00, 4'b0110, 1);
    do_op("dec_ovf",  4'h9, 8'h80, 8'h00, 0,  1,  8'h7F, 8'h00, 4'b0001, 1);
    do_op("and",      4'h4, 8'hF0, 8'h3C, 1,  1,  8'h30, 8'h00, 4'b0000, 1);
    do_op("or",       4'h5, 8'hF0, 8'h3C, 0,  1,  8'hFC, 8'h00, 4'b0100, 1);
    do_op("xor",      4'h6, 8'hF0, 8'h3C, 0,  1,  8'hCC, 8'h00, 4'b0100, 1);
    do_op("not",      4'h7, 8'h0F, 8'h00, 0,  1,  8'hF0, 8'h00, 4'b0100, 1);
    do_op("shl_3",    4'hA, 8'h81, 8'h03, 0,  4,  8'h08, 8'h00, 4'b0000, 1);
    do_op("shl_1",    4'hA, 8'h81, 8'h01, 0,  2,  8'h02, 8'h00, 4'b0010, 1);
    do_op("shl_b8",   4'hA, 8'h81, 8'h08, 0,  1,  8'h81, 8'h00, 4'b0100, 1);
    do_op("shr_0",    4'hB, 8'h81, 8'h00, 0,  1,  8'h81, 8'h00, 4'b0100, 1);
    do_op("shr_1",    4'hB, 8'h81, 8'h01, 0,  2,  8'h40, 8'h00, 4'b0010, 1);
    do_op("rol_1",    4'hC, 8'h81, 8'h01, 0,  2,  8'h03, 8'h00, 4'b0010, 1);
    do_op("ror_2",    4'hD, 8'h81, 8'h02, 0,  3,  8'h60, 8'h00, 4'b0000, 1);
    do_op("ror_1",    4'hD, 8'h01, 8'h01, 0,  2,  8'h80, 8'h00, 4'b0110, 1);
    do_op("pass_0",   4'hF, 8'h00, 8'h55, 0,  1,  8'h00, 8'h00, 4'b1000, 0);
`ifdef ALU_MUL_EN
    do_op("mul_10",   4'hE, 8'h10, 8'h10, 0,  9,  8'h00, 8'h01, 4'b0010, 1);
    do_op("mul_ff",   4'hE, 8'hFF, 8'hFF, 0,  9,  8'h01, 8'hFE, 4'b0110, 1);
    do_op("mul_zero", 4'hE, 8'h00, 8'h37, 0,  9,  8'h00, 8'h00, 4'b1000, 1);
`else
    do_op("opE_pass", 4'hE, 8'h5A, 8'h33, 0,  1,  8'h5A, 8'h00, 4'b0000, 0);
    do_op("opE_zero", 4'hE, 8'h00, 8'h33, 0,  1,  8'h00, 8'h00, 4'b1000, 0);
`endif

    // start pulses while EXEC is running must be dropped.
    @(negedge clk);
    op = 4'hA; a = 8'h01; b = 8'h07; start = 1'b1;
    @(negedge clk);
    dones = 0;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      if (done === 1'b1) begin
        dones++;
        if (first == 0) first = i;
      end
      if (i == 3) begin
        op = 4'h0; a = 8'h11; b = 8'h22;
      end
      start = (i == 3 || i == 4);
      @(negedge clk);
    end
    start = 1'b0;
    check_val("ignore/done_count", dones, 1);
    check_val("ignore/done_cycle", first, 8);
    check_val("ignore/result", {result, Z, N, C, V}, {8'h80, 4'b0100});

    // Reset during EXEC abandons the op without a done pulse.
    @(negedge clk);
    op = 4'hB; a = 8'h80; b = 8'h07; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("midrst/busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst/outputs", {busy, done, flag_en, result, result_hi, Z, N, C, V}, 23'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check_val("midrst/no_done", dones, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
